// File: rtl/fpu_defs_fmac.sv
// Shared width constants for the FMAC datapath.
package fpu_defs_fmac;
  localparam int C_FMAC_WIDTH         = 74;
  localparam int C_FMAC_LEADONE_WIDTH = 7;
  localparam int C_FMAC_TAG_WIDTH     = 4;
endpackage

// File: rtl/fpu_ff.sv
// Leading-one finder: counts zeros above the most significant set bit of in_i.
module fpu_ff #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0]         in_i,
  output logic [$clog2(LEN)-1:0] first_one_o,
  output logic                   no_ones_o
);
  localparam int CW = $clog2(LEN);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    first_one_o = '0;
    for (int i = 0; i < LEN; i++) begin
      if (in_i[i]) first_one_o = CW'(LEN - 1 - i);
    end
    no_ones_o = ~(|in_i);
  end
endmodule

// File: rtl/lza_pipe.sv
// Two-stage leading-zero anticipator: indicator vector in stage 1, leading-one count in stage 2,
// with valid/ready handshaking, flush and an asynchronous active-low reset.
module lza_pipe
  import fpu_defs_fmac::*;
#(
  parameter int C_WIDTH     = C_FMAC_WIDTH,
  parameter int C_LO_WIDTH  = C_FMAC_LEADONE_WIDTH,
  parameter int C_TAG_WIDTH = C_FMAC_TAG_WIDTH
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic [C_WIDTH-1:0]     A_DI,
  input  logic [C_WIDTH-1:0]     B_DI,
  input  logic                   Sub_SI,
  input  logic [C_TAG_WIDTH-1:0] Tag_DI,
  input  logic                   Valid_SI,
  output logic                   Ready_SO,
  input  logic                   Flush_SI,
  output logic [C_LO_WIDTH-1:0]  Leading_one_DO,
  output logic                   No_one_SO,
  output logic [C_TAG_WIDTH-1:0] Tag_DO,
  output logic                   Valid_SO,
  input  logic                   Ready_SI
);
  localparam int FF_W = $clog2(C_WIDTH);

  logic [C_WIDTH-1:0]     bx_p0, t_p0, g_p0, z_p0, f_p0;
  logic [C_WIDTH-1:0]     f_p1;
  logic [C_TAG_WIDTH-1:0] tag_p1, tag_p2;
  logic                   vld_p1, vld_p2;
  logic [C_LO_WIDTH-1:0]  lo_p2;
  logic                   none_p2;
  logic [FF_W-1:0]        ff_cnt;
  logic                   ff_none;
  logic [C_LO_WIDTH-1:0]  lo_cnt;
  logic                   en_p1, en_p2;

  // ---- stage 0 -> 1: indicator generation
  assign bx_p0 = Sub_SI ? ~B_DI : B_DI;
  assign t_p0  = A_DI ^ bx_p0;
  assign g_p0  = A_DI & bx_p0;
  assign z_p0  = ~(A_DI | bx_p0);

  always_comb begin
    f_p0 = '0;
    f_p0[C_WIDTH-1] = ~t_p0[C_WIDTH-1] & t_p0[C_WIDTH-2];
    for (int j = 1; j <= C_WIDTH - 2; j++) begin
      f_p0[j] = ( t_p0[j+1] & ((g_p0[j] & ~z_p0[j-1]) | (z_p0[j] & ~g_p0[j-1])))
              | (~t_p0[j+1] & ((z_p0[j] & ~z_p0[j-1]) | (g_p0[j] & ~g_p0[j-1])));
    end
    f_p0[0] = (t_p0[1] & z_p0[0]) | (~t_p0[1] & (t_p0[0] | g_p0[0]));
  end

  // Flush forces ready high so upstream never stalls on a pipeline being emptied.
  assign Ready_SO = ~vld_p1 | ~vld_p2 | Ready_SI | Flush_SI;
  assign en_p1    = Valid_SI & Ready_SO & ~Flush_SI;
  assign en_p2    = vld_p1 & (~vld_p2 | Ready_SI) & ~Flush_SI;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (Flush_SI) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      // Whenever Ready_SO is high, stage 1 is either empty or draining into stage 2.
      if (Ready_SO) vld_p1 <= Valid_SI;
      if (en_p2)         vld_p2 <= 1'b1;
      else if (Ready_SI) vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (en_p1) begin
      f_p1   <= f_p0;
      tag_p1 <= Tag_DI;
    end
  end

  // ---- stage 1 -> 2: leading-one count
  fpu_ff #(.LEN(C_WIDTH)) u_ff (
    .in_i       (f_p1),
    .first_one_o(ff_cnt),
    .no_ones_o  (ff_none)
  );

  generate
    if (C_LO_WIDTH > FF_W) begin : g_pad
      assign lo_cnt = {{(C_LO_WIDTH-FF_W){1'b0}}, ff_cnt};
    end else begin : g_trunc
      assign lo_cnt = ff_cnt[C_LO_WIDTH-1:0];
    end
  endgenerate

  // Output registers are reset so the presented result reads as zero right after reset.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      lo_p2   <= '0;
      none_p2 <= 1'b0;
      tag_p2  <= '0;
    end else if (en_p2) begin
      lo_p2   <= lo_cnt;
      none_p2 <= ff_none;
      tag_p2  <= tag_p1;
    end
  end

  assign Leading_one_DO = lo_p2;
  assign No_one_SO      = none_p2;
  assign Tag_DO         = tag_p2;
  assign Valid_SO       = vld_p2;
endmodule

// File: tb/tb_lza_pipe.sv
// Directed bench for lza_pipe at C_WIDTH=8, C_LO_WIDTH=3.
module tb_lza_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       sub;
  logic [3:0] tag_in;
  logic       vin, rdy_out, flush;
  logic [2:0] lo;
  logic       none;
  logic [3:0] tag_out;
  logic       vout, rdy_in;

  int n_checks = 0;
  int n_errors = 0;

  lza_pipe #(.C_WIDTH(8), .C_LO_WIDTH(3), .C_TAG_WIDTH(4)) dut (
    .Clk_CI        (clk),
    .Rst_RBI       (rst_n),
    .A_DI          (a),
    .B_DI          (b),
    .Sub_SI        (sub),
    .Tag_DI        (tag_in),
    .Valid_SI      (vin),
    .Ready_SO      (rdy_out),
    .Flush_SI      (flush),
    .Leading_one_DO(lo),
    .No_one_SO     (none),
    .Tag_DO        (tag_out),
    .Valid_SO      (vout),
    .Ready_SI      (rdy_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic s, input logic [3:0] t);
    a = av; b = bv; sub = s; tag_in = t; vin = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] t, input logic [2:0] l, input logic n);
    chk({name, "_valid"}, {31'd0, vout}, 32'd1);
    chk({name, "_tag"}, {28'd0, tag_out}, {28'd0, t});
    chk({name, "_lo"}, {29'd0, lo}, {29'd0, l});
    chk({name, "_none"}, {31'd0, none}, {31'd0, n});
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; sub = 1'b0; tag_in = '0;
    vin = 1'b0; flush = 1'b0; rdy_in = 1'b1;
    #2;
    chk("rst_valid", {31'd0, vout}, 32'd0);
    chk("rst_ready", {31'd0, rdy_out}, 32'd1);
    chk("rst_outs", {24'd0, lo, none, tag_out}, 32'd0);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Streaming at full throughput
    drive(8'h01, 8'h00, 1'b0, 4'd1); cycle();
    chk("lat1_valid", {31'd0, vout}, 32'd0);
    drive(8'h00, 8'h00, 1'b0, 4'd2); cycle();
    chk_out("a01", 4'd1, 3'd6, 1'b0);
    drive(8'h40, 8'h00, 1'b0, 4'd3); cycle();
    chk_out("zero", 4'd2, 3'd0, 1'b1);
    drive(8'h05, 8'h04, 1'b1, 4'd4); cycle();
    chk_out("a40", 4'd3, 3'd0, 1'b0);
    drive(8'h10, 8'h00, 1'b0, 4'd5); cycle();
    chk_out("sub", 4'd4, 3'd0, 1'b1);
    vin = 1'b0; cycle();
    chk_out("a10", 4'd5, 3'd2, 1'b0);
    cycle();
    chk("drain_valid", {31'd0, vout}, 32'd0);

    // Backpressure: fill both stages, hold, then release
    rdy_in = 1'b0;
    drive(8'h01, 8'h00, 1'b0, 4'd1); cycle();
    chk("st1_ready", {31'd0, rdy_out}, 32'd1);
    chk("st1_valid", {31'd0, vout}, 32'd0);
    drive(8'h40, 8'h00, 1'b0, 4'd2); cycle();
    chk("st2_ready", {31'd0, rdy_out}, 32'd0);
    chk_out("st2", 4'd1, 3'd6, 1'b0);
    drive(8'h00, 8'h00, 1'b0, 4'd3); cycle();
    chk_out("hold1", 4'd1, 3'd6, 1'b0);
    chk("hold1_ready", {31'd0, rdy_out}, 32'd0);
    cycle();
    chk_out("hold2", 4'd1, 3'd6, 1'b0);
    rdy_in = 1'b1; #1;
    chk("rel_ready", {31'd0, rdy_out}, 32'd1);
    cycle();
    vin = 1'b0;
    chk_out("rel_t2", 4'd2, 3'd0, 1'b0);
    cycle();
    chk_out("rel_t3", 4'd3, 3'd0, 1'b1);
    cycle();
    chk("rel_drain", {31'd0, vout}, 32'd0);

    // Flush with both stages full
    rdy_in = 1'b0;
    drive(8'h01, 8'h00, 1'b0, 4'd7); cycle();
    drive(8'h10, 8'h00, 1'b0, 4'd8); cycle();
    chk("fl_full", {31'd0, rdy_out}, 32'd0);
    drive(8'h01, 8'h00, 1'b0, 4'd9); flush = 1'b1; #1;
    chk("fl_ready", {31'd0, rdy_out}, 32'd1);
    cycle();
    flush = 1'b0; vin = 1'b0; rdy_in = 1'b1;
    chk("fl_valid0", {31'd0, vout}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_gone", {31'd0, vout}, 32'd0);
    end

    // Asynchronous reset mid-stream
    drive(8'h01, 8'h00, 1'b0, 4'd10); cycle();
    drive(8'h40, 8'h00, 1'b0, 4'd11); cycle();
    chk_out("pre_rst", 4'd10, 3'd6, 1'b0);
    #2 rst_n = 1'b0; #1;
    chk("ar_valid", {31'd0, vout}, 32'd0);
    chk("ar_outs", {24'd0, lo, none, tag_out}, 32'd0);
    chk("ar_ready", {31'd0, rdy_out}, 32'd1);
    vin = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(8'h10, 8'h00, 1'b0, 4'd12); cycle();
    vin = 1'b0;
    chk("ar_lat1", {31'd0, vout}, 32'd0);
    cycle();
    chk_out("ar_first", 4'd12, 3'd2, 1'b0);
    cycle();
    chk("ar_drain", {31'd0, vout}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
